tile_cl_eject: RTL and testbench



---
 rtl/tile_mesh_pkg.sv | 49 ++++
 rtl/tile_cl_eject_if.sv | 31 +++
 rtl/tile_cl_eject_fifo.sv | 87 ++++++++
 rtl/tile_cl_eject.sv | 158 +++++++++++++++
 tb/tb_tile_cl_eject.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_mesh_pkg.sv
// -----------------------------------------------------------------------------
// tile_mesh_pkg
// Shared definitions for the mesh tile ejection logic: packet width, the
// write-request field map inside a 732-bit mesh packet, coordinate width,
// the buffered delivery record and a helper that forms the delivered
// size word.
// -----------------------------------------------------------------------------
package tile_mesh_pkg;

    localparam int PKT_W      = 732;
    localparam int COORD_W    = 2;

    // wrreq field map
    localparam int DATA_LO    = 0;
    localparam int DATA_HI    = 527;
    localparam int TX_LO      = 530;
    localparam int TX_HI      = 534;
    localparam int TY_LO      = 535;
    localparam int TY_HI      = 539;
    localparam int SZ_LO      = 540;
    localparam int SZ_HI      = 579;
    localparam int SHARED_BIT = 580;
    localparam int ADDR_LO    = 581;
    localparam int ADDR_HI    = 728;
    localparam int SND_BIT    = 729;
    localparam int EXPUN_BIT  = 730;
    localparam int EXTRA_BIT  = 731;

    localparam int DATA_W     = DATA_HI - DATA_LO + 1;
    localparam int SZ_W       = SZ_HI - SZ_LO + 1;
    localparam int ADDR_W     = ADDR_HI - ADDR_LO + 1;
    localparam int SIZE_W     = SZ_W + 2;

    // Only the fields that reach the local consumer are buffered.
    typedef struct packed {
        logic              expun;
        logic              shared;
        logic [SZ_W-1:0]   sz;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } deliv_t;

    // Delivered size word: {shared, ~shared, sz}.
    function automatic logic [SIZE_W-1:0] size_word(input logic shared_b,
                                                     input logic [SZ_W-1:0] sz);
        return {shared_b, ~shared_b, sz};
    endfunction

endpackage

// File: rtl/tile_cl_eject_if.sv
// -----------------------------------------------------------------------------
// tile_cl_eject_if
// Local delivery bundle between the ejection block (master) and the local
// consumer (slave).
//   out_valid      master->slave  delivery valid
//   out_ready      slave->master  consumer accepts
//   reqmort_data   master->slave  line data (528 bits)
//   reqmortaddr    master->slave  addr field, 4 x 37 bits
//   reqmort_size   master->slave  {shared, ~shared, sz[39:0]}
//   reqmort_expun  master->slave  expun bit
// -----------------------------------------------------------------------------
interface tile_cl_eject_if;
    import tile_mesh_pkg::*;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       reqmort_data;
    logic [3:0][36:0]        reqmortaddr;
    logic [SIZE_W-1:0]       reqmort_size;
    logic                    reqmort_expun;

    modport master (
        output out_valid, reqmort_data, reqmortaddr, reqmort_size, reqmort_expun,
        input  out_ready
    );

    modport slave (
        input  out_valid, reqmort_data, reqmortaddr, reqmort_size, reqmort_expun,
        output out_ready
    );
endinterface

// File: rtl/tile_cl_eject_fifo.sv
// -----------------------------------------------------------------------------
// tile_cl_eject_fifo
// Single-direction ejection FIFO with occupancy tracking, upstream stall and
// overflow detection. Storage is not reset; only pointers and occupancy are.
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   push_i   in   write wdata_i (dropped when full and not popping)
//   pop_i    in   consume the head entry
//   wdata_i  in   entry to write
//   rdata_o  out  head entry
//   empty_o  out  occupancy == 0
//   stall_o  out  occupancy >= DEPTH-2
//   ovf_o    out  push arrived while full with no pop this cycle
// -----------------------------------------------------------------------------
module tile_cl_eject_fifo
    import tile_mesh_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  logic   pop_i,
    input  deliv_t wdata_i,
    output deliv_t rdata_o,
    output logic   empty_o,
    output logic   stall_o,
    output logic   ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    deliv_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_s, wr_en_s, rd_en_s;

    // Accept/drop decision and next pointer/occupancy values
    always_comb begin
        empty_o = (cnt_q == CW'(0));
        full_s  = (cnt_q == CW'(DEPTH));
        stall_o = (cnt_q >= CW'(DEPTH - 2));
        rd_en_s = pop_i && !empty_o;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en_s = push_i && (!full_s || rd_en_s);
        ovf_o   = push_i && full_s && !rd_en_s;
        rdata_o = mem_q[rd_ptr_q];

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage, deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tile_cl_eject.sv
// -----------------------------------------------------------------------------
// tile_cl_eject
// Ejection stage of a mesh tile. Packets on the two mesh links addressed to
// this tile are buffered per direction and delivered to the local consumer
// under round-robin arbitration; all other valid packets are forwarded one
// cycle later. Bit 731 of each outgoing link carries stall to upstream.
//   clk         in   clock
//   rst         in   asynchronous active-low reset
//   X_intf_in   in   [1:0][731:0] mesh links (0 = back, 1 = fwd)
//   X_intf_out  out  [1:0][731:0] forwarded packets, bit 731 = stall
//   ovf_err     out  sticky overflow flag
//   dlv         if   local delivery bundle (tile_cl_eject_if.master)
// Optional build macro TILE_EJECT_BYPASS_EN: when both FIFOs are empty,
// exactly one link ejects and the consumer is ready, the packet is handed
// over combinationally in the same cycle instead of being buffered.
// -----------------------------------------------------------------------------
module tile_cl_eject
    import tile_mesh_pkg::*;
#(
    parameter int TILE_X = 0,
    parameter int TILE_Y = 0,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0][PKT_W-1:0]  X_intf_in,
    output logic [1:0][PKT_W-1:0]  X_intf_out,
    output logic                   ovf_err,
    tile_cl_eject_if.master        dlv
);
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(TILE_X);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(TILE_Y);

    logic [1:0]            hit_s, fwd_s, push_s, pop_s;
    logic [1:0]            empty_s, stall_s, ovf_s;
    deliv_t                in_s [2];
    deliv_t                rd_s [2];
    deliv_t                deliv_s;
    logic                  bypass_s, sel_s, out_valid_s, fire_s;
    logic                  prio_q, prio_d;
    logic                  lock_q, lock_d, lock_sel_q, lock_sel_d;
    logic                  ovf_q, ovf_d;
    logic [1:0][PKT_W-2:0] pass_q, pass_d;
    logic                  unused_extra_s;

    // Input bit 731 has no meaning on an incoming link.
    assign unused_extra_s = X_intf_in[0][EXTRA_BIT] ^ X_intf_in[1][EXTRA_BIT];

    // Per-link destination decode and field extraction
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            hit_s[d] = X_intf_in[d][SND_BIT]
                       && (X_intf_in[d][TX_LO +: COORD_W] == MY_X)
                       && (X_intf_in[d][TY_LO +: COORD_W] == MY_Y);
            fwd_s[d] = X_intf_in[d][SND_BIT] && !hit_s[d];
            in_s[d].expun  = X_intf_in[d][EXPUN_BIT];
            in_s[d].shared = X_intf_in[d][SHARED_BIT];
            in_s[d].sz     = X_intf_in[d][SZ_HI:SZ_LO];
            in_s[d].addr   = X_intf_in[d][ADDR_HI:ADDR_LO];
            in_s[d].data   = X_intf_in[d][DATA_HI:DATA_LO];
            pass_d[d]      = fwd_s[d] ? X_intf_in[d][PKT_W-2:0] : '0;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        tile_cl_eject_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_s[g]),
            .pop_i   (pop_s[g]),
            .wdata_i (in_s[g]),
            .rdata_o (rd_s[g]),
            .empty_o (empty_s[g]),
            .stall_o (stall_s[g]),
            .ovf_o   (ovf_s[g])
        );
    end

    // Bypass decision, arbitration and delivery handshake
    always_comb begin
`ifdef TILE_EJECT_BYPASS_EN
        bypass_s = (&empty_s) && (hit_s[0] ^ hit_s[1]) && dlv.out_ready;
`else
        bypass_s = 1'b0;
`endif
        push_s = hit_s & ~{2{bypass_s}};

        // A stalled delivery keeps its source so the outputs stay stable even
        // if the other FIFO fills up meanwhile.
        if (bypass_s) begin
            sel_s = hit_s[1];
        end else if (lock_q) begin
            sel_s = lock_sel_q;
        end else if (empty_s[0]) begin
            sel_s = 1'b1;
        end else if (empty_s[1]) begin
            sel_s = 1'b0;
        end else begin
            sel_s = prio_q;
        end

        out_valid_s = bypass_s || !(&empty_s);
        deliv_s     = bypass_s ? in_s[sel_s] : rd_s[sel_s];
        fire_s      = out_valid_s && dlv.out_ready;

        pop_s = 2'b00;
        if (fire_s && !bypass_s) begin
            pop_s[sel_s] = 1'b1;
        end else begin
            pop_s = 2'b00;
        end

        // Priority goes to the direction that was not just served.
        prio_d = fire_s ? ~sel_s : prio_q;

        if (out_valid_s && !dlv.out_ready) begin
            lock_d     = 1'b1;
            lock_sel_d = sel_s;
        end else begin
            lock_d     = 1'b0;
            lock_sel_d = lock_sel_q;
        end

        ovf_d = ovf_q || (|ovf_s);
    end

    // Arbiter state, sticky overflow flag and forwarded-packet registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            ovf_q      <= 1'b0;
            pass_q     <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            ovf_q      <= ovf_d;
            pass_q     <= pass_d;
        end
    end

    // Outgoing links: forwarded packet plus FIFO stall
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            X_intf_out[d] = {stall_s[d], pass_q[d]};
        end
    end

    assign ovf_err           = ovf_q;
    assign dlv.out_valid     = out_valid_s;
    assign dlv.reqmort_data  = deliv_s.data;
    assign dlv.reqmortaddr   = deliv_s.addr;
    assign dlv.reqmort_size  = size_word(deliv_s.shared, deliv_s.sz);
    assign dlv.reqmort_expun = deliv_s.expun;

endmodule

// File: tb/tb_tile_cl_eject.sv
// -----------------------------------------------------------------------------
// tb_tile_cl_eject
// Self-checking bench for tile_cl_eject at tile (1,2), DEPTH 8: routing
// vector table, overflow/stall, hold-while-stalled, reset discard,
// round-robin alternation, full push+pop, and delivery latency.
// -----------------------------------------------------------------------------
module tb_tile_cl_eject;
    import tile_mesh_pkg::*;

    localparam int TXP   = 1;
    localparam int TYP   = 2;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [1:0][PKT_W-1:0] xin;
    logic [1:0][PKT_W-1:0] xout;
    logic                  ovf_err;
    logic [PKT_W-1:0]      act_s;
    logic [PKT_W-1:0]      sb_q [$];
    int                    vectors = 0;
    int                    miscompares = 0;

    tile_cl_eject_if dlv_if ();

    tile_cl_eject #(.TILE_X(TXP), .TILE_Y(TYP), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .X_intf_in  (xin),
        .X_intf_out (xout),
        .ovf_err    (ovf_err),
        .dlv        (dlv_if)
    );

    always #5 clk = ~clk;

    assign act_s = {13'd0, dlv_if.reqmort_expun, dlv_if.reqmort_size,
                    dlv_if.reqmortaddr, dlv_if.reqmort_data};

    typedef struct {
        logic [4:0] tx0, ty0, tx1, ty1;
        logic       snd0, snd1;
        logic       ej0, ej1, ps0, ps1;
    } vec_t;

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [4:0] tx,
                                                input logic [4:0] ty,
                                                input logic snd);
        logic [PKT_W-1:0] p;
        p = '0;
        for (int i = 0; i < 22; i++) p[i*32 +: 32] = $urandom;
        p[731:704] = 28'($urandom);
        p[534:530] = tx;
        p[539:535] = ty;
        p[729]     = snd;
        return p;
    endfunction

    // Expected delivery: {pad, expun, shared, ~shared, sz, addr, data}
    function automatic logic [PKT_W-1:0] exp_of(input logic [PKT_W-1:0] p);
        return {13'd0, p[730], p[580], ~p[580], p[579:540], p[728:581], p[527:0]};
    endfunction

    task automatic check(input string name, input logic [PKT_W-1:0] act,
                         input logic [PKT_W-1:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check1(name, sb_q.size() == 0, 1'b1);
    endtask

    // Scoreboard: every completed delivery must match the oldest expectation
    always @(negedge clk) begin
        if (rst && dlv_if.out_valid && dlv_if.out_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL deliver: unexpected delivery got %0h expected none", act_s);
            end else begin
                check("deliver", act_s, sb_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             tbl [7];
        logic [PKT_W-1:0] p0, p1, pk;
        logic             exp_v;

        //            tx0    ty0    tx1    ty1    snd0  snd1  ej0   ej1   ps0   ps1
        tbl[0] = '{5'd1,  5'd2,  5'd1,  5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{5'd1,  5'd2,  5'd3,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{5'd5,  5'd10, 5'd1,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{5'd2,  5'd1,  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{5'd1,  5'd2,  5'd29, 5'd22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{5'd1,  5'd1,  5'd2,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{5'd1,  5'd2,  5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        xin = '0;
        dlv_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset out_valid", dlv_if.out_valid, 1'b0);
        check1("reset ovf_err", ovf_err, 1'b0);
        check("reset xout0", xout[0], '0);
        check("reset xout1", xout[1], '0);
        rst = 1'b1;
        dlv_if.out_ready = 1'b1;
        step();

        // Routing table
        for (int v = 0; v < 7; v++) begin
            p0 = mk_pkt(tbl[v].tx0, tbl[v].ty0, tbl[v].snd0);
            p1 = mk_pkt(tbl[v].tx1, tbl[v].ty1, tbl[v].snd1);
            xin[0] = p0;
            xin[1] = p1;
            if (tbl[v].ej0) sb_q.push_back(exp_of(p0));
            if (tbl[v].ej1) sb_q.push_back(exp_of(p1));
            step();
            xin = '0;
            check($sformatf("v%0d xout0", v), xout[0], tbl[v].ps0 ? {1'b0, p0[730:0]} : '0);
            check($sformatf("v%0d xout1", v), xout[1], tbl[v].ps1 ? {1'b0, p1[730:0]} : '0);
`ifdef TILE_EJECT_BYPASS_EN
            exp_v = tbl[v].ej0 & tbl[v].ej1;
`else
            exp_v = tbl[v].ej0 | tbl[v].ej1;
`endif
            check1($sformatf("v%0d out_valid", v), dlv_if.out_valid, exp_v);
            repeat (3) step();
        end
        check1("table drained", sb_q.size() == 0, 1'b1);

        // Fill dir0 with consumer stalled: stall at 6, overflow on 9th
        dlv_if.out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            pk = mk_pkt(5'd1, 5'd2, 1'b1);
            xin[0] = pk;
            if (k <= 8) sb_q.push_back(exp_of(pk));
            step();
            check1($sformatf("stall after push %0d", k), xout[0][731], k >= 6);
            check1($sformatf("ovf after push %0d", k), ovf_err, k >= 9);
        end
        xin = '0;
        check("ejected not forwarded", xout[0] & {1'b0, {(PKT_W-1){1'b1}}}, '0);
        check1("dir1 no stall", xout[1][731], 1'b0);
        check("held data", act_s, sb_q[0]);
        step();
        check("held data later", act_s, sb_q[0]);
        check1("held valid", dlv_if.out_valid, 1'b1);
        dlv_if.out_ready = 1'b1;
        drain("overflow drain");
        check1("ovf sticky", ovf_err, 1'b1);
        check1("stall cleared", xout[0][731], 1'b0);

        // Reset with queued packets discards them
        dlv_if.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            xin[0] = mk_pkt(5'd1, 5'd2, 1'b1);
            step();
        end
        xin = '0;
        check1("queued valid", dlv_if.out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check1("rst out_valid", dlv_if.out_valid, 1'b0);
        check1("rst ovf_err", ovf_err, 1'b0);
        check("rst xout0", xout[0], '0);
        step();
        rst = 1'b1;
        dlv_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check1($sformatf("no stale %0d", k), dlv_if.out_valid, 1'b0);
        end

        // Three packets per FIFO deliver alternately 0,1,0,1,0,1
        dlv_if.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            p0 = mk_pkt(5'd1, 5'd2, 1'b1);
            p1 = mk_pkt(5'd29, 5'd22, 1'b1);
            xin[0] = p0;
            xin[1] = p1;
            sb_q.push_back(exp_of(p0));
            sb_q.push_back(exp_of(p1));
            step();
        end
        xin = '0;
        check1("rr valid", dlv_if.out_valid, 1'b1);
        dlv_if.out_ready = 1'b1;
        drain("rr drain");

        // Full FIFO: push with pop keeps it full, further push overflows
        dlv_if.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pk = mk_pkt(5'd1, 5'd2, 1'b1);
            xin[0] = pk;
            sb_q.push_back(exp_of(pk));
            step();
        end
        check1("full stall", xout[0][731], 1'b1);
        pk = mk_pkt(5'd1, 5'd2, 1'b1);
        xin[0] = pk;
        sb_q.push_back(exp_of(pk));
        dlv_if.out_ready = 1'b1;
        step();
        check1("push+pop no ovf", ovf_err, 1'b0);
        dlv_if.out_ready = 1'b0;
        xin[0] = mk_pkt(5'd1, 5'd2, 1'b1);
        step();
        xin = '0;
        check1("still full ovf", ovf_err, 1'b1);
        dlv_if.out_ready = 1'b1;
        drain("full drain");

        // Delivery latency with empty FIFOs and ready consumer
        pk = mk_pkt(5'd1, 5'd2, 1'b1);
        xin[0] = pk;
        sb_q.push_back(exp_of(pk));
        #1;
`ifdef TILE_EJECT_BYPASS_EN
        check1("same-cycle valid", dlv_if.out_valid, 1'b1);
`else
        check1("same-cycle valid", dlv_if.out_valid, 1'b0);
`endif
        step();
        xin = '0;
`ifdef TILE_EJECT_BYPASS_EN
        check1("next-cycle valid", dlv_if.out_valid, 1'b0);
`else
        check1("next-cycle valid", dlv_if.out_valid, 1'b1);
`endif
        drain("latency drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
